// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO: configurable data width, optional parity,
// one or two stop bits, back-to-back frames while words are queued.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start_tx,
  input  logic [DATA_BITS-1:0]               data_tx,
  output logic                               tx_ready,
  output logic                               tx_busy,
  output logic                               tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               tx_out
);

  localparam int unsigned DIV    = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BAUD_W = $clog2(DIV);
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [BAUD_W-1:0]    r_baud_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_parity;
  logic                 w_parity_nxt;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_count;
  logic [LVL_W-1:0]     w_count_nxt;
  logic [DATA_BITS-1:0] w_head;

  logic                 r_tx_ready;
  logic                 r_tx_busy;
  logic                 r_tx_done;
  logic                 r_tx_out;
  logic                 w_tx_out_nxt;
  logic                 w_tx_busy_nxt;
  logic                 w_tx_done_nxt;

  logic                 w_tick;
  logic                 w_last_data;
  logic                 w_last_stop;
  logic                 w_empty;
  logic                 w_frame_end;
  logic                 w_pop;
  logic                 w_push;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_tick      = (r_baud_cnt == BAUD_W'(DIV - 1));
  assign w_last_data = (r_bit_cnt == BIT_W'(DATA_BITS - 1));
  assign w_last_stop = (r_bit_cnt == BIT_W'(STOP_BITS - 1));
  assign w_empty     = (r_count == '0);
  assign w_frame_end = (r_state == S_STOP) && w_tick && w_last_stop;
  // A queued word is taken either from idle or on the last stop-bit clock.
  assign w_pop       = !w_empty && ((r_state == S_IDLE) || w_frame_end);
  // tx_ready is the registered pre-edge "not full", so a write while full is dropped.
  assign w_push      = start_tx && r_tx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick && w_last_data) begin
          w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_frame_end) begin
          w_state_nxt = w_pop ? S_START : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Next values of the line, status flags and shift register, registered below.
  always_comb begin
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_tx_out_nxt  = 1'b1;
    w_tx_busy_nxt = (w_state_nxt != S_IDLE);
    w_tx_done_nxt = w_frame_end;
    if (w_pop) begin
      w_shift_nxt  = w_head;
      w_parity_nxt = (PARITY == 1) ? ~^w_head : ^w_head;
    end else if ((r_state == S_DATA) && w_tick) begin
      w_shift_nxt = r_shift >> 1;
    end
    case (w_state_nxt)
      S_START:  w_tx_out_nxt = 1'b0;
      S_DATA:   w_tx_out_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_out_nxt = r_parity;
      default:  w_tx_out_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx_out  <= 1'b1;
      r_tx_busy <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_tx_out  <= w_tx_out_nxt;
      r_tx_busy <= w_tx_busy_nxt;
      r_tx_done <= w_tx_done_nxt;
    end
  end

  // Baud counter restarts at every bit boundary; bit counter indexes data or stop bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (w_pop || (r_state == S_IDLE) || w_tick) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
      end
      if (w_tick && ((r_state == S_DATA) || (r_state == S_STOP))) begin
        r_bit_cnt <= (w_state_nxt != r_state) ? '0 : r_bit_cnt + BIT_W'(1);
      end
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + LVL_W'(1);
      2'b01:   w_count_nxt = r_count - LVL_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_tx_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count    <= w_count_nxt;
      r_tx_ready <= (w_count_nxt != LVL_W'(FIFO_DEPTH));
    end
  end

  // Storage needs no reset: the count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_tx;
    end
  end

  assign tx_ready   = r_tx_ready;
  assign tx_busy    = r_tx_busy;
  assign tx_done    = r_tx_done;
  assign fifo_level = r_count;
  assign tx_out     = r_tx_out;

endmodule
